// File: rtl/keyboard_controller.sv
// PS/2 scan-code set 2 front end producing Game-of-Life control strobes on clk_in.
// Optional build macro PS2_PARITY_CHECK_EN: drop frames whose odd-parity bit is wrong.
module keyboard_controller #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk_in,
    input  logic        reset_n,
    input  logic        ps2_clock,
    input  logic        ps2_data,
    output logic        start,
    output logic        pause,
    output logic        clear,
    output logic        manual,
    output logic [3:0]  setting,
    output logic [15:0] file_id
);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BREAK,
        ST_EXT,
        ST_EXT_BREAK
    } state_e;

    logic [1:0]      clk_sync_q;
    logic [1:0]      dat_sync_q;
    logic            clk_prev_q;
    logic            fall;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [9:0]      frame_q, frame_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            frame_ok;
    logic [7:0]      code;
    state_e          state_q, state_d;
    logic [3:0]      held_q, held_d;
    logic            start_q, start_d;
    logic            pause_q, pause_d;
    logic            clear_q, clear_d;
    logic            manual_q, manual_d;
    logic [3:0]      setting_q, setting_d;
    logic [15:0]     file_id_q, file_id_d;

    // Synchronisers reset to the PS/2 idle level so release never fakes an edge.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clock};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
            clk_prev_q <= clk_sync_q[1];
        end
    end

    assign fall = clk_prev_q & ~clk_sync_q[1];

    // Bits shift in from the top: after ten falls [0]=start, [8:1]=data, [9]=parity.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        wd_d      = '0;
        if (fall) begin
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                frame_d   = {dat_sync_q[1], frame_q[9:1]};
            end
        end else if (bit_cnt_q != '0) begin
            if (wd_q == WD_W'(TIMEOUT_CYCLES)) begin
                bit_cnt_d = '0;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt_q <= '0;
            wd_q      <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            wd_q      <= wd_d;
        end
    end

    always_ff @(posedge clk_in) begin
        frame_q <= frame_d;
    end

    assign code = frame_q[8:1];

`ifdef PS2_PARITY_CHECK_EN
    logic parity_ok;
    assign parity_ok = ^frame_q[9:1];
    assign frame_ok  = fall && (bit_cnt_q == 4'd10) && !frame_q[0] && dat_sync_q[1] && parity_ok;
`else
    assign frame_ok  = fall && (bit_cnt_q == 4'd10) && !frame_q[0] && dat_sync_q[1];
`endif

    // Decoder: held flags [0]=Space [1]=P [2]=C [3]=M gate the non-repeating keys.
    always_comb begin
        state_d   = state_q;
        held_d    = held_q;
        start_d   = 1'b0;
        pause_d   = 1'b0;
        clear_d   = 1'b0;
        setting_d = '0;
        manual_d  = manual_q;
        file_id_d = file_id_q;
        if (frame_ok) begin
            case (state_q)
                ST_IDLE: begin
                    if (code == 8'hF0) begin
                        state_d = ST_BREAK;
                    end else if (code == 8'hE0) begin
                        state_d = ST_EXT;
                    end else begin
                        case (code)
                            8'h29: if (!held_q[0]) begin held_d[0] = 1'b1; start_d = 1'b1; end
                            8'h4D: if (!held_q[1]) begin held_d[1] = 1'b1; pause_d = 1'b1; end
                            8'h21: if (!held_q[2]) begin held_d[2] = 1'b1; clear_d = 1'b1; end
                            8'h3A: if (!held_q[3]) begin held_d[3] = 1'b1; manual_d = ~manual_q; end
                            8'h1C: setting_d = 4'b0001;
                            8'h1D: setting_d = 4'b0010;
                            8'h1B: setting_d = 4'b0100;
                            8'h23: setting_d = 4'b1000;
                            8'h45: file_id_d = 16'd0;
                            8'h16: file_id_d = 16'd1;
                            8'h1E: file_id_d = 16'd2;
                            8'h26: file_id_d = 16'd3;
                            8'h25: file_id_d = 16'd4;
                            8'h2E: file_id_d = 16'd5;
                            8'h36: file_id_d = 16'd6;
                            8'h3D: file_id_d = 16'd7;
                            8'h3E: file_id_d = 16'd8;
                            8'h46: file_id_d = 16'd9;
                            default: ;
                        endcase
                    end
                end
                ST_BREAK: begin
                    state_d = ST_IDLE;
                    case (code)
                        8'h29:   held_d[0] = 1'b0;
                        8'h4D:   held_d[1] = 1'b0;
                        8'h21:   held_d[2] = 1'b0;
                        8'h3A:   held_d[3] = 1'b0;
                        default: ;
                    endcase
                end
                ST_EXT: begin
                    state_d = (code == 8'hF0) ? ST_EXT_BREAK : ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            held_q    <= '0;
            start_q   <= 1'b0;
            pause_q   <= 1'b0;
            clear_q   <= 1'b0;
            manual_q  <= 1'b0;
            setting_q <= '0;
            file_id_q <= '0;
        end else begin
            state_q   <= state_d;
            held_q    <= held_d;
            start_q   <= start_d;
            pause_q   <= pause_d;
            clear_q   <= clear_d;
            manual_q  <= manual_d;
            setting_q <= setting_d;
            file_id_q <= file_id_d;
        end
    end

    assign start   = start_q;
    assign pause   = pause_q;
    assign clear   = clear_q;
    assign manual  = manual_q;
    assign setting = setting_q;
    assign file_id = file_id_q;

endmodule

// File: tb/tb_keyboard_controller.sv
// Bench for keyboard_controller: directed and random PS/2 frames against a key-level model.
module tb_keyboard_controller;
    localparam int HALF = 10;

    logic        clk_in    = 1'b0;
    logic        reset_n   = 1'b0;
    logic        ps2_clock = 1'b1;
    logic        ps2_data  = 1'b1;
    logic        start, pause, clear, manual;
    logic [3:0]  setting;
    logic [15:0] file_id;

    int checks = 0;
    int errors = 0;

    keyboard_controller #(.TIMEOUT_CYCLES(50000)) dut (
        .clk_in    (clk_in),
        .reset_n   (reset_n),
        .ps2_clock (ps2_clock),
        .ps2_data  (ps2_data),
        .start     (start),
        .pause     (pause),
        .clear     (clear),
        .manual    (manual),
        .setting   (setting),
        .file_id   (file_id)
    );

    always #10 clk_in = ~clk_in;

    // Output monitor: running pulse counts, over-long pulses, simultaneous changes
    int          n_start = 0, n_pause = 0, n_clear = 0, n_wide = 0, n_multi = 0;
    int          n_set[4] = '{0, 0, 0, 0};
    logic        p_start = 1'b0, p_pause = 1'b0, p_clear = 1'b0, p_manual = 1'b0;
    logic [3:0]  p_set  = '0;
    logic [15:0] p_file = '0;

    always @(negedge clk_in) begin
        int ev;
        ev = 0;
        if (start === 1'b1) begin n_start++; ev++; end
        if (pause === 1'b1) begin n_pause++; ev++; end
        if (clear === 1'b1) begin n_clear++; ev++; end
        for (int i = 0; i < 4; i++) begin
            if (setting[i] === 1'b1) begin n_set[i]++; ev++; end
        end
        if (manual !== p_manual) ev++;
        if (file_id !== p_file) ev++;
        if ((start & p_start) | (pause & p_pause) | (clear & p_clear) | (|(setting & p_set))) n_wide++;
        if (ev > 1) n_multi++;
        p_start = start; p_pause = pause; p_clear = clear;
        p_set = setting; p_manual = manual; p_file = file_id;
    end

    // Key-level reference model
    bit pend_brk = 1'b0, pend_ext = 1'b0;
    bit held[4]  = '{0, 0, 0, 0};
    bit m_manual = 1'b0;
    int m_file   = 0;
    int e_start, e_pause, e_clear;
    int e_set[4];
    logic [7:0] digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] pool [24] = '{8'h29, 8'h4D, 8'h21, 8'h3A, 8'h1C, 8'h1D, 8'h1B, 8'h23,
                              8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                              8'h3E, 8'h46, 8'hF0, 8'hF0, 8'hF0, 8'hE0, 8'h70, 8'h5A};

    function automatic int key_idx(input logic [7:0] b);
        case (b)
            8'h29:   return 0;
            8'h4D:   return 1;
            8'h21:   return 2;
            8'h3A:   return 3;
            default: return -1;
        endcase
    endfunction

    function automatic int set_idx(input logic [7:0] b);
        case (b)
            8'h1C:   return 0;
            8'h1D:   return 1;
            8'h1B:   return 2;
            8'h23:   return 3;
            default: return -1;
        endcase
    endfunction

    task automatic model_byte(input logic [7:0] b);
        int k;
        if (pend_ext && pend_brk) begin
            pend_ext = 0; pend_brk = 0;
        end else if (pend_ext) begin
            if (b == 8'hF0) pend_brk = 1;
            else pend_ext = 0;
        end else if (pend_brk) begin
            k = key_idx(b);
            if (k >= 0) held[k] = 0;
            pend_brk = 0;
        end else if (b == 8'hF0) begin
            pend_brk = 1;
        end else if (b == 8'hE0) begin
            pend_ext = 1;
        end else begin
            k = key_idx(b);
            if (k >= 0 && !held[k]) begin
                held[k] = 1;
                case (k)
                    0: e_start++;
                    1: e_pause++;
                    2: e_clear++;
                    default: m_manual = !m_manual;
                endcase
            end
            k = set_idx(b);
            if (k >= 0) e_set[k]++;
            for (int d = 0; d < 10; d++) if (digits[d] == b) m_file = d;
        end
    endtask

    task automatic model_reset();
        pend_brk = 0; pend_ext = 0; m_manual = 0; m_file = 0;
        for (int i = 0; i < 4; i++) held[i] = 0;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge clk_in);
        ps2_clock = 1'b0;
        repeat (HALF) @(negedge clk_in);
        ps2_clock = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input string tag);
        int   s0, s1, s2, w0, mu0;
        int   st0[4];
        logic par;
        bit   acc;
        s0 = n_start; s1 = n_pause; s2 = n_clear; w0 = n_wide; mu0 = n_multi;
        for (int i = 0; i < 4; i++) begin st0[i] = n_set[i]; e_set[i] = 0; end
        e_start = 0; e_pause = 0; e_clear = 0;
        par = ~^b;
        if (bad_par) par = ~par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_bit(!bad_stop);
        ps2_data = 1'b1;
        repeat (12) @(negedge clk_in);
        acc = !bad_stop;
`ifdef PS2_PARITY_CHECK_EN
        if (bad_par) acc = 0;
`endif
        if (acc) model_byte(b);
        check($sformatf("%s start", tag), n_start - s0, e_start);
        check($sformatf("%s pause", tag), n_pause - s1, e_pause);
        check($sformatf("%s clear", tag), n_clear - s2, e_clear);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s setting%0d", tag, i), n_set[i] - st0[i], e_set[i]);
        check($sformatf("%s wide_pulse", tag), n_wide - w0, 0);
        check($sformatf("%s multi_change", tag), n_multi - mu0, 0);
        check($sformatf("%s manual", tag), int'(manual), int'(m_manual));
        check($sformatf("%s file_id", tag), int'(file_id), m_file);
    endtask

    task automatic check_reset_outputs(input string tag);
        check($sformatf("%s start", tag), int'(start), 0);
        check($sformatf("%s pause", tag), int'(pause), 0);
        check($sformatf("%s clear", tag), int'(clear), 0);
        check($sformatf("%s manual", tag), int'(manual), 0);
        check($sformatf("%s setting", tag), int'(setting), 0);
        check($sformatf("%s file_id", tag), int'(file_id), 0);
    endtask

    initial begin
        logic [7:0] b;
        repeat (5) @(negedge clk_in);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        repeat (5) @(negedge clk_in);

        send_frame(8'h29, 0, 0, "space");
        send_frame(8'h29, 0, 0, "space_rep");
        send_frame(8'hF0, 0, 0, "space_brk0");
        send_frame(8'h29, 0, 0, "space_brk1");
        send_frame(8'h29, 0, 0, "space_again");

        send_frame(8'h3A, 0, 0, "m1");
        send_frame(8'hF0, 0, 0, "m1_brk0");
        send_frame(8'h3A, 0, 0, "m1_brk1");
        send_frame(8'h3A, 0, 0, "m2");
        send_frame(8'h3A, 0, 0, "m2_rep");
        send_frame(8'hF0, 0, 0, "m2_brk0");
        send_frame(8'h3A, 0, 0, "m2_brk1");
        send_frame(8'h3A, 0, 0, "m3");

        send_frame(8'h1D, 0, 0, "w1");
        send_frame(8'h1D, 0, 0, "w2");
        send_frame(8'h1D, 0, 0, "w3");
        send_frame(8'hF0, 0, 0, "w_brk0");
        send_frame(8'h1D, 0, 0, "w_brk1");

        send_frame(8'h3E, 0, 0, "digit8");
        send_frame(8'hE0, 0, 0, "ext0");
        send_frame(8'h70, 0, 0, "ext1");

        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (50100) @(negedge clk_in);
        send_frame(8'h4D, 0, 0, "after_timeout");

        send_frame(8'h21, 1, 0, "clear_badpar");
        send_frame(8'hF0, 0, 0, "clear_brk0");
        send_frame(8'h21, 0, 0, "clear_brk1");
        send_frame(8'h21, 0, 0, "clear_goodpar");
        send_frame(8'h1C, 0, 1, "bad_stop");

        for (int n = 0; n < 50; n++) begin
            if ($urandom_range(0, 9) == 0) b = 8'($urandom_range(0, 255));
            else b = pool[$urandom_range(0, 23)];
            send_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, $sformatf("rand%0d", n));
        end

        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        reset_n = 1'b0;
        repeat (3) @(negedge clk_in);
        check_reset_outputs("mid_reset");
        model_reset();
        ps2_data = 1'b1;
        reset_n  = 1'b1;
        repeat (5) @(negedge clk_in);
        send_frame(8'h29, 0, 0, "post_reset_space");
        send_frame(8'h3A, 0, 0, "post_reset_m");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
